// File: rtl/umem_pkg.sv
// Shared definitions for the unified-memory arbiter: widths, FSM states, defaults.
package umem_pkg;

    localparam int AW = 8;   // memory byte address width
    localparam int DW = 8;   // memory data width
    localparam int IW = 16;  // instruction width (two bytes)

    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_ACK  = 2'd1,
        IF_HI  = 2'd2,
        IF_ACK = 2'd3
    } state_e;

endpackage

// File: rtl/umem_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the unified-memory arbiter.
// master = CPU core plus memory (drives requests and read data),
// slave  = the arbiter itself.
interface umem_arbiter_if;

    logic                      if_req;
    logic [umem_pkg::AW-1:0]   if_adr;
    logic [umem_pkg::IW-1:0]   if_instr;
    logic                      if_valid;

    logic                      d_req;
    logic                      d_we;
    logic [umem_pkg::AW-1:0]   d_adr;
    logic [umem_pkg::DW-1:0]   d_wdata;
    logic [umem_pkg::DW-1:0]   d_rdata;
    logic                      d_valid;

    logic                      mem_en;
    logic                      mem_we;
    logic [umem_pkg::AW-1:0]   mem_adr;
    logic [umem_pkg::DW-1:0]   mem_wdata;
    logic [umem_pkg::DW-1:0]   mem_rdata;

    logic                      stall;

    modport master (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        input  if_instr, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_adr, mem_wdata, stall
    );

    modport slave (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, mem_rdata,
        output if_instr, if_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_adr, mem_wdata, stall
    );

endinterface

// File: rtl/umem_arbiter.sv
// Shares one byte-wide single-port synchronous memory between a 16-bit
// instruction-fetch port and an 8-bit data port. Data wins ties unless the
// fetch has already waited STARVE_LIMIT data grants. A fetch is two reads
// (low byte, then high byte at adr+1 mod 256) and cannot be interrupted.
module umem_arbiter
    import umem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    umem_arbiter_if.slave  bus
);

    localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e          state_q, state_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            is_load_q, is_load_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            grant_data, grant_fetch;
    logic            men, mwe, ifv, dv;
    logic [AW-1:0]   madr;
    logic [DW-1:0]   mwd, drd;
    logic [IW-1:0]   ifi;

    // Arbitration, memory sequencing and next-state selection.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        adr_d       = adr_q;
        is_load_d   = is_load_q;
        lo_d        = lo_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        men         = 1'b0;
        mwe         = 1'b0;
        madr        = '0;
        mwd         = '0;
        ifv         = 1'b0;
        dv          = 1'b0;
        ifi         = instr_q;
        drd         = rdata_q;

        case (state_q)
            IDLE: begin
                grant_fetch = bus.if_req & (~bus.d_req | (starve_q == LIMIT));
                grant_data  = bus.d_req & ~grant_fetch;
                if (grant_data) begin
                    men       = 1'b1;
                    mwe       = bus.d_we;
                    madr      = bus.d_adr;
                    mwd       = bus.d_wdata;
                    is_load_d = ~bus.d_we;
                    state_d   = D_ACK;
                    // Only grants that make a pending fetch wait count toward starvation.
                    if (bus.if_req && (starve_q != LIMIT)) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (grant_fetch) begin
                    men      = 1'b1;
                    madr     = bus.if_adr;
                    adr_d    = bus.if_adr;
                    starve_d = '0;
                    state_d  = IF_HI;
                end
            end
            D_ACK: begin
                dv = 1'b1;
                if (is_load_q) begin
                    drd     = bus.mem_rdata;
                    rdata_d = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            IF_HI: begin
                lo_d    = bus.mem_rdata;
                men     = 1'b1;
                madr    = adr_q + AW'(1);  // wraps 0xFF -> 0x00
                state_d = IF_ACK;
            end
            IF_ACK: begin
                ifv     = 1'b1;
                ifi     = {bus.mem_rdata, lo_q};
                instr_d = {bus.mem_rdata, lo_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, starvation counter, latched address and hold registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            adr_q     <= '0;
            is_load_q <= 1'b0;
            lo_q      <= '0;
            instr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            adr_q     <= adr_d;
            is_load_q <= is_load_d;
            lo_q      <= lo_d;
            instr_q   <= instr_d;
            rdata_q   <= rdata_d;
        end
    end

    // Combinational outputs are forced to zero while reset is held, since
    // IDLE would otherwise issue an access for any request already present.
    assign bus.mem_en    = reset & men;
    assign bus.mem_we    = reset & mwe;
    assign bus.mem_adr   = reset ? madr : '0;
    assign bus.mem_wdata = reset ? mwd  : '0;
    assign bus.if_valid  = reset & ifv;
    assign bus.d_valid   = reset & dv;
    assign bus.if_instr  = reset ? ifi  : '0;
    assign bus.d_rdata   = reset ? drd  : '0;
    assign bus.stall     = reset & ((bus.if_req & ~ifv) | (bus.d_req & ~dv));

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Arbiter and sequencer that shares one single-port, byte-wide synchronous memory between the CPU's instruction-fetch port (16-bit instructions) and its data port (8-bit loads/stores).
- It replaces the separate instruction and data memories with a unified 256-byte memory.
- It assembles each 16-bit instruction from two byte reads.
- It reports `stall` so the CPU core can freeze its PC and pipeline while a request is pending.

## Interface
Parameters:
- `STARVE_LIMIT`, default 3: consecutive data grants, made while a fetch is waiting, after which the next arbitration goes to fetch.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held high until `if_valid`.
- `if_adr` in 8: byte address of the instruction's low byte.
- `if_instr` out 16: fetched instruction, {byte at adr+1, byte at adr}.
- `if_valid` out 1: one-cycle pulse; `if_instr` valid.
- `d_req` in 1: data request; held high until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_adr` in 8: data byte address.
- `d_wdata` in 8: store data.
- `d_rdata` out 8: load data.
- `d_valid` out 1: one-cycle pulse; load data valid or store done.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write this cycle.
- `mem_adr` out 8: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: read data, valid the cycle after a read issue.
- `stall` out 1: a held request has not yet received its valid pulse.

## Operation
- FSM states:
  - IDLE: arbitration, and issue of the first access.
  - D_ACK: data transaction done.
  - IF_HI: low byte captured, high byte issued.
  - IF_ACK: instruction complete.
- Requests are sampled only in IDLE. The address, `d_we` and `d_wdata` are latched at the issue edge, so later input changes have no effect on a transaction in flight.
- Arbitration in IDLE:
  - If only one request is present, it is granted.
  - If both are present, data wins, unless `starve_cnt == STARVE_LIMIT`; then fetch wins.
  - `starve_cnt` increments on each data grant while `if_req` is high.
  - It clears on any fetch grant.
  - It saturates at `STARVE_LIMIT`.
- Data grant:
  - The access is driven combinationally in IDLE: `mem_en=1`, `mem_we=d_we`, `mem_adr=d_adr`, `mem_wdata=d_wdata`.
  - Next state is D_ACK.
- D_ACK:
  - `d_valid=1`.
  - For a load, `d_rdata=mem_rdata` and the value is captured into a hold register.
  - Next state is IDLE.
- Fetch grant:
  - In IDLE, issue a read at `if_adr`; next state is IF_HI.
  - In IF_HI, capture the low byte from `mem_rdata` and issue a read at latched adr+1, modulo 256; next state is IF_ACK.
  - In IF_ACK, `if_valid=1` and `if_instr={mem_rdata, lo}`, captured into a hold register; next state is IDLE.
- A fetch is atomic: a data request arriving during IF_HI or IF_ACK waits.
- `if_instr` and `d_rdata` hold their last value outside the ack states.
- A store leaves `d_rdata` unchanged.
- `stall = (if_req & ~if_valid) | (d_req & ~d_valid)`.
- Address wrap: `if_adr=0xFF` fetches its high byte from 0x00.
- The memory is idle (`mem_en=0`) in D_ACK, in IF_ACK, and in IDLE with no request.

## Timing
- Reset (`reset=0`, asynchronous):
  - State becomes IDLE and `starve_cnt` becomes 0.
  - `if_instr`, `d_rdata`, `if_valid`, `d_valid` and `stall` become 0.
  - The memory outputs are 0 while reset is asserted.
  - A transaction in flight is dropped with no valid pulse; the requester keeps its req high and is re-served after release.
- Data latency: issue in cycle T, `d_valid` in T+1.
  - Back-to-back throughput is one data transaction per 2 cycles.
- Fetch latency: issue in cycle T, high byte issued in T+1, `if_valid` in T+2.
  - Throughput is one fetch per 3 cycles.
- A req still high in the IDLE cycle after its valid pulse starts a new transaction.
  - Requesters drop req in the cycle after valid if no new request is intended.
- Simultaneous `if_req` and `d_req` in IDLE: exactly one is issued, per the arbitration rule; the other stays stalled.
- A store is written at the rising edge ending the issue cycle.
  - A load of the same address in the next transaction returns the new value.

## Structure
- Shared package `umem_pkg` holds:
  - the state enum (IDLE, D_ACK, IF_HI, IF_ACK);
  - the address and data width constants, AW=8, DW=8, IW=16;
  - the default `STARVE_LIMIT`.
- Single module; no sub-module needed. The starvation counter and hold registers stay inline.
- The bench supplies a behavioural 256×8 synchronous memory model with 1-cycle read latency.

## Test plan
- Reset, then fetch with `if_adr=0x10`, mem[0x10]=0x34, mem[0x11]=0x12 -> `if_valid` 2 cycles after issue, `if_instr=0x1234`; `stall` high in IDLE and IF_HI, low in IF_ACK.
- Store 0xA5 to 0x40, then load 0x40 -> each `d_valid` 1 cycle after its issue; `d_rdata=0xA5`; `if_instr` unchanged.
- `if_req` and `d_req` held continuously with `STARVE_LIMIT=3` -> grant order D,D,D,F,D,D,D,F; no fetch waits more than 3 data grants.
- Fetch at `if_adr=0xFF`, mem[0xFF]=0xCD, mem[0x00]=0xAB -> `if_instr=0xABCD`.
- `d_req` asserted in the IF_HI cycle -> data issued only in the IDLE cycle after `if_valid`; `d_valid` one cycle later.
- `reset` pulsed low during IF_HI -> no `if_valid`; all outputs 0 during reset; `if_req` held high is re-served with full 2-cycle latency after release.
